// File: rtl/exec_wb_stage.sv
// ----------------------------------------------------------------------------
// exec_wb_stage
//
// Execute-to-writeback stage. It evaluates an ARM condition code against the
// architectural flags (apsr). Results whose condition passes are queued for
// the register file. Results whose condition fails are consumed and dropped.
// A passing instruction with in_set_flags updates apsr at its accept edge, so
// the next instruction accepted one cycle later already sees the new flags.
//
// Optional feature (macro EXEC_WB_SKID_EN):
//   undefined : a single output register. in_ready depends combinationally on
//               out_ready. Queue states are EMPTY and ONE.
//   defined   : adds a one-entry skid register. in_ready comes from registered
//               state only, so it is independent of out_ready. Queue states
//               are EMPTY, ONE and TWO. FIFO order is preserved.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous flush: empties the queue, blocks input
//   in_valid/in_ready   upstream handshake
//   in_result, in_flags ALU result and flags ([3]=V [2]=N [1]=C [0]=Z)
//   in_set_flags        instruction updates apsr
//   in_cond             ARM condition code
//   in_dest, in_wr_en   writeback register index and write enable
//   out_valid/out_ready downstream (register file) handshake
//   out_result, out_dest, out_wr_en  writeback payload
//   apsr                architectural flags, same bit order as in_flags
//   queue_state         current queue state (0=EMPTY 1=ONE 2=TWO), for debug
//
// Handshake: a beat transfers on a rising edge where valid && ready. When
// valid is asserted and ready is low, the payload is held stable. Neither side
// waits on the other's valid/ready before it asserts its own signal.
// ----------------------------------------------------------------------------
module exec_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [3:0]        in_flags,
   input  logic              in_set_flags,
   input  logic [3:0]        in_cond,
   input  logic [REG_W-1:0]  in_dest,
   input  logic              in_wr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_W-1:0]  out_dest,
   output logic              out_wr_en,
   output logic [3:0]        apsr,
   output logic [1:0]        queue_state
);

`ifdef EXEC_WB_SKID_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

   state_t state_q;
   state_t state_d;

   logic accept;
   logic pass;
   logic push;
   logic retire;
   logic load_head_in;
   logic load_head_skid;
   logic load_skid;

`ifdef EXEC_WB_SKID_EN
   logic [DATA_W-1:0] skid_result;
   logic [REG_W-1:0]  skid_dest;
   logic              skid_wr_en;
`endif

   // Condition evaluation against the flags that hold before the edge.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic v, n, c, z;
      logic r;
      v = f[3];
      n = f[2];
      c = f[1];
      z = f[0];
      case (cond)
         4'b0000: r = z;
         4'b0001: r = !z;
         4'b0010: r = c;
         4'b0011: r = !c;
         4'b0100: r = n;
         4'b0101: r = !n;
         4'b0110: r = v;
         4'b0111: r = !v;
         4'b1000: r = c & !z;
         4'b1001: r = !c | z;
         4'b1010: r = (n == v);
         4'b1011: r = (n != v);
         4'b1100: r = !z & (n == v);
         4'b1101: r = z | (n != v);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   assign out_valid   = (state_q != EMPTY);
   assign queue_state = state_q;

`ifdef EXEC_WB_SKID_EN
   // Only registered state feeds in_ready. Room for one more entry exists
   // unless both registers are full.
   assign in_ready = (state_q != TWO) && !flush;
`else
   assign in_ready = (!out_valid || out_ready) && !flush;
`endif

   assign accept = in_valid && in_ready;
   assign pass   = cond_pass(in_cond, apsr);
   assign push   = accept && pass;
   assign retire = out_valid && out_ready;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and register-load controls
   always_comb begin
      state_d        = state_q;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d      = ONE;
                  load_head_in = 1'b1;
               end
            end
            ONE: begin
`ifdef EXEC_WB_SKID_EN
               if (push && retire) begin
                  load_head_in = 1'b1;
               end else if (push) begin
                  // Head is stalled. The new entry waits behind it.
                  state_d   = TWO;
                  load_skid = 1'b1;
               end else if (retire) begin
                  state_d = EMPTY;
               end
`else
               // Without skid, push in ONE only happens when retire does too.
               if (push) begin
                  load_head_in = 1'b1;
               end else if (retire) begin
                  state_d = EMPTY;
               end
`endif
            end
`ifdef EXEC_WB_SKID_EN
            TWO: begin
               if (retire) begin
                  state_d        = ONE;
                  load_head_skid = 1'b1;
               end
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   // Head (output) register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_result <= '0;
         out_dest   <= '0;
         out_wr_en  <= 1'b0;
      end else if (load_head_in) begin
         out_result <= in_result;
         out_dest   <= in_dest;
         out_wr_en  <= in_wr_en;
`ifdef EXEC_WB_SKID_EN
      end else if (load_head_skid) begin
         out_result <= skid_result;
         out_dest   <= skid_dest;
         out_wr_en  <= skid_wr_en;
`endif
      end
   end

`ifdef EXEC_WB_SKID_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_result <= '0;
         skid_dest   <= '0;
         skid_wr_en  <= 1'b0;
      end else if (load_skid) begin
         skid_result <= in_result;
         skid_dest   <= in_dest;
         skid_wr_en  <= in_wr_en;
      end
   end
`else
   // Without skid, the head register only loads from the input.
   logic unused_skid;
   assign unused_skid = load_head_skid | load_skid;
`endif

   // Architectural flags. Flush blocks accept, so flush leaves apsr alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         apsr <= 4'b0000;
      end else if (push && in_set_flags) begin
         apsr <= in_flags;
      end
   end

endmodule

// File: tb/tb_exec_wb_stage.sv
module tb_exec_wb_stage;
   localparam int DATA_W = 32;
   localparam int REG_W  = 4;
   localparam int E_W    = DATA_W + REG_W + 1;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [3:0]        in_flags;
   logic              in_set_flags;
   logic [3:0]        in_cond;
   logic [REG_W-1:0]  in_dest;
   logic              in_wr_en;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [REG_W-1:0]  out_dest;
   logic              out_wr_en;
   logic [3:0]        apsr;
   logic [1:0]        queue_state;

   exec_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_flags(in_flags), .in_set_flags(in_set_flags), .in_cond(in_cond),
      .in_dest(in_dest), .in_wr_en(in_wr_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_dest(out_dest), .out_wr_en(out_wr_en), .apsr(apsr),
      .queue_state(queue_state)
   );

   // scoreboard / reference model
   logic [E_W-1:0]    exp_q[$];
   logic [3:0]        m_apsr;
   logic              m_last_acc;
   logic [DATA_W-1:0] dut_ret[$];
   int total = 0;
   int bad   = 0;

`ifdef EXEC_WB_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Condition table with flags read as V,N,C,Z.
   function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
      logic v, n, c, z;
      v = f[3]; n = f[2]; c = f[1]; z = f[0];
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   // driver
   task automatic drive(input logic iv, input logic [DATA_W-1:0] res, input logic [3:0] fl4,
                        input logic sf, input logic [3:0] cond, input logic [REG_W-1:0] dst,
                        input logic wr, input logic ordy, input logic fl);
      in_valid     = iv;
      in_result    = res;
      in_flags     = fl4;
      in_set_flags = sf;
      in_cond      = cond;
      in_dest      = dst;
      in_wr_en     = wr;
      out_ready    = ordy;
      flush        = fl;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, '0, 4'h0, 1'b0, 4'hE, '0, 1'b0, ordy, 1'b0);
   endtask

   // One clock cycle. The caller drives inputs just after a falling edge.
   // Outputs are checked against the model, and the model then advances on
   // the rising edge. The task returns on the next falling edge.
   task automatic cycle();
      logic exp_rdy, p, acc, ret;
      #1;
      if (flush) exp_rdy = 1'b0;
      else if (CAP == 2) exp_rdy = (exp_q.size() < 2);
      else exp_rdy = (exp_q.size() == 0) || out_ready;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("payload", {out_result, out_dest, out_wr_en}, exp_q[0]);
      check("apsr", apsr, m_apsr);
      if (out_valid && out_ready) dut_ret.push_back(out_result);
      p   = model_cond(in_cond, m_apsr);
      acc = in_valid && exp_rdy;
      ret = (exp_q.size() != 0) && out_ready;
      @(posedge clk);
      m_last_acc = acc;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (ret) void'(exp_q.pop_front());
         if (acc && p) begin
            exp_q.push_back({in_result, in_dest, in_wr_en});
            if (in_set_flags) m_apsr = in_flags;
         end
      end
      @(negedge clk);
   endtask

   logic [DATA_W-1:0] items[$];

   initial begin
      m_apsr = 4'b0000;
      m_last_acc = 1'b0;
      idle(1'b1);
      // reset values while reset is held
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, '0);
      check("rst_out_dest", out_dest, '0);
      check("rst_out_wr_en", out_wr_en, 1'b0);
      check("rst_apsr", apsr, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      // AL instruction, result appears one cycle later
      drive(1'b1, 32'h5, 4'b0000, 1'b1, 4'b1110, 4'd3, 1'b1, 1'b1, 1'b0);
      cycle();
      idle(1'b1);
      #1;
      check("al_out_valid", out_valid, 1'b1);
      check("al_out_result", out_result, 32'h5);
      check("al_apsr", apsr, 4'b0000);
      cycle();

      // Z=1, then NE fails: nothing queued, apsr unchanged
      drive(1'b1, 32'h0, 4'b0001, 1'b1, 4'b1110, 4'd1, 1'b0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h7, 4'b1111, 1'b1, 4'b0001, 4'd2, 1'b1, 1'b1, 1'b0);
      cycle();
      idle(1'b1);
      #1;
      check("ne_out_valid", out_valid, 1'b0);
      check("ne_apsr", apsr, 4'b0001);
      check("ne_in_ready", in_ready, 1'b1);
      cycle();

      // back-to-back: clear flags, CMP sets Z, EQ next cycle passes
      drive(1'b1, 32'h0, 4'b0000, 1'b1, 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h0, 4'b0001, 1'b1, 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h9, 4'b0000, 1'b0, 4'b0000, 4'd5, 1'b1, 1'b1, 1'b0);
      cycle();
      idle(1'b1);
      #1;
      check("b2b_out_valid", out_valid, 1'b1);
      check("b2b_out_result", out_result, 32'h9);
      cycle();

      // backpressure: A,B,C offered while out_ready=0, then released
      dut_ret.delete();
      items = '{32'hA, 32'hB, 32'hC};
      for (int i = 0; i < 12; i++) begin
         if (items.size() != 0)
            drive(1'b1, items[0], 4'b0000, 1'b0, 4'b1110, 4'd4, 1'b1, (i >= 4), 1'b0);
         else
            idle(1'b1);
         if (i == 3) begin
            #1;
            check("bp_head", out_result, 32'hA);
            check("bp_in_ready", in_ready, 1'b0);
         end
         cycle();
         if (m_last_acc && items.size() != 0) void'(items.pop_front());
      end
      check("bp_ret_count", dut_ret.size(), 3);
      if (dut_ret.size() == 3) begin
         check("bp_ret0", dut_ret[0], 32'hA);
         check("bp_ret1", dut_ret[1], 32'hB);
         check("bp_ret2", dut_ret[2], 32'hC);
      end

      // flush with an entry held and input offered
      drive(1'b1, 32'h11, 4'b0000, 1'b0, 4'b1110, 4'd6, 1'b1, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 32'h22, 4'b1111, 1'b1, 4'b1110, 4'd7, 1'b1, 1'b0, 1'b1);
      #1;
      check("fl_in_ready", in_ready, 1'b0);
      check("fl_out_valid_before", out_valid, 1'b1);
      cycle();
      idle(1'b0);
      #1;
      check("fl_out_valid", out_valid, 1'b0);
      check("fl_apsr", apsr, 4'b0001);
      cycle();

      // asynchronous reset during a stall
      drive(1'b1, 32'h33, 4'b1010, 1'b1, 4'b1110, 4'd8, 1'b1, 1'b0, 1'b0);
      cycle();
      idle(1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_out_valid", out_valid, 1'b0);
      check("ar_apsr", apsr, 4'b0000);
      check("ar_out_result", out_result, '0);
      exp_q.delete();
      m_apsr = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
               REG_W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exec_wb_stage.md
EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result width.
REQ-002 SHALL have parameter REG_W, default 4, destination register index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  in  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  in  1  upstream ALU result valid.
REQ-007 SHALL have port in_ready  out  1  stage can accept.
REQ-008 SHALL have port in_result  in  DATA_W  ALU result.
REQ-009 SHALL have port in_flags  in  4  ALU flags [3]=V [2]=N [1]=C [0]=Z.
REQ-010 SHALL have port in_set_flags  in  1  instruction updates APSR.
REQ-011 SHALL have port in_cond  in  4  ARM condition code.
REQ-012 SHALL have port in_dest / in_wr_en  in  REG_W / 1  writeback register and enable.
REQ-013 SHALL have port out_valid  out  1  writeback entry valid.
REQ-014 SHALL have port out_ready  in  1  register file accepts.
REQ-015 SHALL have port out_result / out_dest / out_wr_en  out  DATA_W / REG_W / 1  writeback payload.
REQ-016 SHALL have port apsr  out  4  architectural flags, same bit order as in_flags.

Function
REQ-017 SHALL accept a transaction when in_valid && in_ready at a rising edge.
REQ-018 SHALL evaluate in_cond against apsr value before the edge: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 and 1111 always.
REQ-019 SHALL, on accepted passing transaction, enqueue {in_result, in_dest, in_wr_en} and, if in_set_flags, load apsr<=in_flags at that edge.
REQ-020 SHALL, on accepted failing transaction, consume it, enqueue nothing, leave apsr unchanged.
REQ-021 SHALL make apsr written by transaction N visible to condition of transaction N+1 accepted next cycle (no bubble, no bypass needed).
REQ-022 SHALL hold out_* stable while out_valid && !out_ready; entry retires on out_valid && out_ready.
REQ-023 SHALL implement queue states EMPTY, ONE (and TWO when skid enabled); out_valid=1 in any non-EMPTY state; latency in_valid->out_valid one cycle.
REQ-024 SHALL, with simultaneous accept and retire in ONE, stay in ONE with new payload.
REQ-025 SHALL, on flush, go to EMPTY next edge, drive in_ready=0 that cycle, keep apsr unchanged; flush has priority over accept and retire.

Reset
REQ-026 SHALL on reset_n low immediately force state EMPTY, out_valid=0, out_result=0, out_dest=0, out_wr_en=0, apsr=4'b0000; in_ready=1 after deassertion.
REQ-027 SHALL discard any in-flight entries when reset asserts mid-operation.

Configuration
REQ-028 SHALL, with EXEC_WB_SKID_EN defined, include a one-entry skid buffer: in_ready=(state!=TWO)&&!flush, registered, independent of out_ready; FIFO order preserved.
REQ-029 SHALL, without EXEC_WB_SKID_EN, use a single register: in_ready=(!out_valid||out_ready)&&!flush; state TWO absent.

Verification
REQ-030 SHALL check: reset, then in_result=0x00000005, cond=1110, set_flags=1, flags=4'b0000, out_ready=1 -> next cycle out_valid=1, out_result=0x5, apsr=0000.
REQ-031 SHALL check: apsr Z=1, cond=0001 (NE), in_result=0x7 -> no out_valid, apsr unchanged, in_ready stays 1.
REQ-032 SHALL check back-to-back: CMP flags=0001 set_flags=1 then cond=0000 (EQ) next cycle, result 0x9 -> second passes, out_result=0x9.
REQ-033 SHALL check backpressure: out_ready=0 with 3 transactions 0xA,0xB,0xC -> without skid 0xA held, in_ready=0; with skid 0xA,0xB stored, in_ready=0; release -> retire A,B,C in order.
REQ-034 SHALL check flush with out_valid=1 and in_valid=1 -> EMPTY next cycle, input not accepted, apsr unchanged.
REQ-035 SHALL check reset_n low mid-stall -> out_valid=0 and apsr=0000 without clock edge.
